// File: rtl/wb_regfile.sv
// Writeback stage: selects load/ALU data, commits it to the GPR file and serves two combinational read ports.
// Single-cycle commit with no backpressure. Define WB_REGFILE_BYPASS_EN for write-through reads.
module wb_regfile #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            WB_ctlwb,
  input  logic [DATA_W-1:0]     WB_rdata,
  input  logic [DATA_W-1:0]     WB_alu_out,
  input  logic [REG_ADDR_W-1:0] WB_rd,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  output logic [DATA_W-1:0]     ID_rsdata,
  output logic [DATA_W-1:0]     ID_rtdata,
  output logic                  fwd_we,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      wb_count
);

  localparam int DEPTH = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] gpr [DEPTH];
  logic [DATA_W-1:0] wdata;
  logic              we;

  assign wdata = WB_ctlwb[0] ? WB_rdata : WB_alu_out;
  // r0 is hardwired to zero, so a RegWrite targeting it is not a commit.
  assign we    = WB_ctlwb[1] && (WB_rd != '0);

  assign fwd_we   = we;
  assign fwd_rd   = WB_rd;
  assign fwd_data = wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) gpr[i] <= '0;
      wb_count <= '0;
    end else if (we) begin
      gpr[WB_rd] <= wdata;
      wb_count   <= wb_count + CNT_W'(1);
    end
  end

  always_comb begin
    ID_rsdata = gpr[ID_rs];
    ID_rtdata = gpr[ID_rt];
`ifdef WB_REGFILE_BYPASS_EN
    if (we && (ID_rs == WB_rd)) ID_rsdata = wdata;
    if (we && (ID_rt == WB_rd)) ID_rtdata = wdata;
`else
    // Same-cycle hazards are resolved by forwarding/stall logic outside this block.
`endif
    if (ID_rs == '0) ID_rsdata = '0;
    if (ID_rt == '0) ID_rtdata = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a default-width instance plus a CNT_W=4 instance for counter wrap.
module tb_wb_regfile;
  logic        clk;
  logic        rst;
  logic [1:0]  WB_ctlwb;
  logic [31:0] WB_rdata;
  logic [31:0] WB_alu_out;
  logic [4:0]  WB_rd;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic [31:0] ID_rsdata, ID_rtdata, fwd_data;
  logic        fwd_we;
  logic [4:0]  fwd_rd;
  logic [31:0] wb_count;
  logic [31:0] s_rsdata, s_rtdata, s_fwd_data;
  logic        s_fwd_we;
  logic [4:0]  s_fwd_rd;
  logic [3:0]  s_wb_count;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk(clk), .rst(rst), .WB_ctlwb(WB_ctlwb), .WB_rdata(WB_rdata),
    .WB_alu_out(WB_alu_out), .WB_rd(WB_rd), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_rsdata(ID_rsdata), .ID_rtdata(ID_rtdata), .fwd_we(fwd_we),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .wb_count(wb_count)
  );

  wb_regfile #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .WB_ctlwb(WB_ctlwb), .WB_rdata(WB_rdata),
    .WB_alu_out(WB_alu_out), .WB_rd(WB_rd), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_rsdata(s_rsdata), .ID_rtdata(s_rtdata), .fwd_we(s_fwd_we),
    .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data), .wb_count(s_wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; WB_ctlwb = 2'b00; WB_rdata = '0; WB_alu_out = '0;
    WB_rd = '0; ID_rs = 5'd5; ID_rt = 5'd9;
    tick();
    chk("reset_rs", ID_rsdata, 32'h0);
    chk("reset_rt", ID_rtdata, 32'h0);
    chk("reset_count", wb_count, 32'd0);
    chk("reset_fwd_we_idle", {31'd0, fwd_we}, 32'd0);

    // Write attempted while reset is held: forwarding tap follows inputs, state stays clear.
    WB_ctlwb = 2'b10; WB_rd = 5'd4; WB_alu_out = 32'hCAFE_0004; ID_rs = 5'd4;
    #1;
    chk("reset_fwd_we_follows", {31'd0, fwd_we}, 32'd1);
    tick();
    chk("reset_write_discarded", ID_rsdata, 32'h0);
    chk("reset_write_nocount", wb_count, 32'd0);
    WB_ctlwb = 2'b00;
    rst = 1'b0;

    // Populate r5 and r9, then pulse reset between edges.
    WB_ctlwb = 2'b10; WB_rd = 5'd5; WB_alu_out = 32'h0000_0055; tick();
    WB_rd = 5'd9; WB_alu_out = 32'h0000_0099; tick();
    WB_ctlwb = 2'b00; ID_rs = 5'd5; ID_rt = 5'd9; #1;
    chk("pre_rst_r5", ID_rsdata, 32'h0000_0055);
    chk("pre_rst_r9", ID_rtdata, 32'h0000_0099);
    chk("pre_rst_count", wb_count, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("midrst_r5", ID_rsdata, 32'h0);
    chk("midrst_r9", ID_rtdata, 32'h0);
    chk("midrst_count", wb_count, 32'd0);
    chk("midrst_count_small", {28'd0, s_wb_count}, 32'd0);
    rst = 1'b0;
    tick();

    // ALU writeback; load data must be ignored.
    WB_ctlwb = 2'b10; WB_rd = 5'd7; WB_alu_out = 32'h1234_5678; WB_rdata = 32'hFFFF_FFFF;
    #1;
    chk("alu_fwd_data", fwd_data, 32'h1234_5678);
    chk("alu_fwd_rd", {27'd0, fwd_rd}, 32'd7);
    tick();
    WB_ctlwb = 2'b00; ID_rs = 5'd7; #1;
    chk("alu_r7", ID_rsdata, 32'h1234_5678);
    chk("alu_count", wb_count, 32'd1);

    // Load writeback with same-cycle forwarding.
    WB_ctlwb = 2'b11; WB_rd = 5'd8; WB_rdata = 32'hDEAD_BEEF; WB_alu_out = 32'h1;
    #1;
    chk("load_fwd_data", fwd_data, 32'hDEAD_BEEF);
    chk("load_fwd_we", {31'd0, fwd_we}, 32'd1);
    tick();
    WB_ctlwb = 2'b00; ID_rt = 5'd8; #1;
    chk("load_r8", ID_rtdata, 32'hDEAD_BEEF);
    chk("load_count", wb_count, 32'd2);

    // RegWrite to r0.
    WB_ctlwb = 2'b11; WB_rd = 5'd0; WB_rdata = 32'hFFFF_FFFF; WB_alu_out = 32'hFFFF_FFFF;
    ID_rs = 5'd0;
    #1;
    chk("r0_fwd_we", {31'd0, fwd_we}, 32'd0);
    tick();
    WB_ctlwb = 2'b00; #1;
    chk("r0_read", ID_rsdata, 32'h0);
    chk("r0_count", wb_count, 32'd2);

    // Write and read the same register in one cycle.
    WB_ctlwb = 2'b10; WB_rd = 5'd3; WB_alu_out = 32'hA5A5_A5A5; ID_rs = 5'd3; ID_rt = 5'd3;
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    chk("raw_same_rs", ID_rsdata, 32'hA5A5_A5A5);
    chk("raw_same_rt", ID_rtdata, 32'hA5A5_A5A5);
`else
    chk("raw_same_rs", ID_rsdata, 32'h0);
    chk("raw_same_rt", ID_rtdata, 32'h0);
`endif
    tick();
    WB_ctlwb = 2'b00; #1;
    chk("raw_next_rs", ID_rsdata, 32'hA5A5_A5A5);
    chk("raw_next_rt", ID_rtdata, 32'hA5A5_A5A5);
    chk("raw_count", wb_count, 32'd3);

    // Counter wrap on the 4-bit instance: 17 writes from a fresh reset.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    WB_ctlwb = 2'b10; WB_rd = 5'd1; ID_rs = 5'd1;
    for (int i = 1; i <= 17; i++) begin
      WB_alu_out = 32'h100 + i;
      tick();
      if (i == 16) chk("wrap_at_16", {28'd0, s_wb_count}, 32'd0);
    end
    WB_ctlwb = 2'b00; #1;
    chk("wrap_small_count", {28'd0, s_wb_count}, 32'd1);
    chk("wrap_big_count", wb_count, 32'd17);
    chk("wrap_r1", ID_rsdata, 32'h0000_0111);
    chk("wrap_small_r1", s_rsdata, 32'h0000_0111);

    // RegWrite=0 cycles leave everything untouched, whatever MemtoReg and data are.
    for (int i = 0; i < 3; i++) begin
      WB_ctlwb = 2'(i & 1); WB_rd = 5'd1; WB_rdata = 32'hBAD0_0000 + i; WB_alu_out = 32'hBAD1_0000 + i;
      tick();
    end
    WB_ctlwb = 2'b00; #1;
    chk("idle_small_count", {28'd0, s_wb_count}, 32'd1);
    chk("idle_big_count", wb_count, 32'd17);
    chk("idle_r1", ID_rsdata, 32'h0000_0111);
    chk("idle_fwd_we", {31'd0, s_fwd_we}, 32'd0);
    chk("idle_fwd_rd", {27'd0, s_fwd_rd}, 32'd1);
    chk("idle_fwd_data", s_fwd_data, 32'hBAD1_0002);
    ID_rt = 5'd8; #1;
    chk("idle_small_r8_after_rst", s_rtdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
